// File: rtl/uart_alu_pkg.sv
// Shared types and defaults for the UART <-> ALU command sequencer.
package uart_alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;
  localparam int NB_OUT_DEF  = 16;

  // Result bytes go out least-significant byte first.
  localparam bit LSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_TX_LO   = 3'd4,
    ST_WAIT_LO = 3'd5,
    ST_TX_HI   = 3'd6,
    ST_WAIT_HI = 3'd7
  } state_t;

  // States in which the sequencer is still collecting command bytes.
  function automatic logic is_collecting(state_t s);
    return (s == ST_WAIT_B) || (s == ST_WAIT_OP);
  endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// Bundle of UART RX/TX, ALU and status signals around the sequencer.
// master = sequencer side, slave = UART/ALU environment side.
interface uart_alu_sequencer_if
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int NB_OUT  = NB_OUT_DEF
);

  logic               i_rx_done;
  logic [NB_DATA-1:0] i_rx_data;
  logic [NB_OUT-1:0]  i_result;
  logic               i_tx_busy;
  logic               i_tx_done;

  logic [NB_DATA-1:0] o_operand1;
  logic [NB_DATA-1:0] o_operand2;
  logic [NB_OP-1:0]   o_opcode;
  logic               o_alu_valid;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_busy;
  logic               o_frame_err;
  logic               o_overrun;

  modport master (
    input  i_rx_done, i_rx_data, i_result, i_tx_busy, i_tx_done,
    output o_operand1, o_operand2, o_opcode, o_alu_valid, o_tx_start,
           o_tx_data, o_busy, o_frame_err, o_overrun
  );

  modport slave (
    output i_rx_done, i_rx_data, i_result, i_tx_busy, i_tx_done,
    input  o_operand1, o_operand2, o_opcode, o_alu_valid, o_tx_start,
           o_tx_data, o_busy, o_frame_err, o_overrun
  );

endinterface

// File: rtl/seq_timeout_counter.sv
// Inter-byte timeout counter. o_expired is high in the cycle whose closing
// edge brings the count to LIMIT, so a registered error flag set on that
// edge coincides with the count reaching LIMIT.
module seq_timeout_counter #(
  parameter int CW    = 23,
  parameter int LIMIT = 4_999_999
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic o_expired
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_inc;

  assign count_inc = count_q + 1'b1;

  // Count enabled cycles; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_inc;
    end
  end

  assign o_expired = enable && !clear && (count_inc == LAST);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects operand1/operand2/opcode bytes from the UART receiver, drives the
// ALU for one EXEC cycle, registers the result and sends it back as two bytes.
// Every output comes from a flop.
module uart_alu_sequencer
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int NB_OUT         = NB_OUT_DEF,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input logic                 i_clk,
  input logic                 i_reset,
  uart_alu_sequencer_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t state_q, state_d;

  logic [NB_DATA-1:0] operand1_q, operand2_q;
  logic [NB_OP-1:0]   opcode_q;
  logic [NB_OUT-1:0]  result_q;
  logic [NB_OUT-1:0]  result_src;
  logic [NB_DATA-1:0] first_byte, second_byte;

  logic               alu_valid_q, alu_valid_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  logic collecting;
  logic tmo_expired;

  assign collecting = is_collecting(state_q);

  seq_timeout_counter #(
    .CW    (TW),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .clear     (!collecting || bus.i_rx_done),
    .enable    (collecting),
    .o_expired (tmo_expired)
  );

  // In EXEC the result is still on the ALU input; afterwards it is in result_q.
  assign result_src  = (state_q == ST_EXEC) ? bus.i_result : result_q;
  assign first_byte  = LSB_FIRST ? result_src[NB_DATA-1:0] : result_src[NB_OUT-1:NB_DATA];
  assign second_byte = LSB_FIRST ? result_src[NB_OUT-1:NB_DATA] : result_src[NB_DATA-1:0];

  // State register.
  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; an incoming byte outranks a same-cycle timeout.
  // NOTE: state_d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.i_rx_done) state_d = ST_WAIT_B;
      ST_WAIT_B:  if (bus.i_rx_done) state_d = ST_WAIT_OP;
                  else if (tmo_expired) state_d = ST_IDLE;
      ST_WAIT_OP: if (bus.i_rx_done) state_d = ST_EXEC;
                  else if (tmo_expired) state_d = ST_IDLE;
      ST_EXEC:    state_d = ST_TX_LO;
      ST_TX_LO:   if (tx_start_q) state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (bus.i_tx_done) state_d = ST_TX_HI;
      ST_TX_HI:   if (tx_start_q) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (bus.i_tx_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output decode: values the output flops take at the coming edge.
  always_comb begin
    alu_valid_d = (state_d == ST_EXEC);
    busy_d      = (state_d != ST_IDLE);
    // A TX state not yet launched keeps state_d in that TX state.
    tx_start_d  = ((state_d == ST_TX_LO) || (state_d == ST_TX_HI)) && !bus.i_tx_busy;
    frame_err_d = collecting && tmo_expired && !bus.i_rx_done;
    overrun_d   = bus.i_rx_done && !collecting && (state_q != ST_IDLE);
    tx_data_d   = tx_data_q;
    if ((state_d == ST_TX_LO) || (state_d == ST_WAIT_LO)) tx_data_d = first_byte;
    if ((state_d == ST_TX_HI) || (state_d == ST_WAIT_HI)) tx_data_d = second_byte;
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      operand1_q  <= '0;
      operand2_q  <= '0;
      opcode_q    <= '0;
      result_q    <= '0;
      alu_valid_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (bus.i_rx_done) begin
        case (state_q)
          ST_IDLE:    operand1_q <= bus.i_rx_data;
          ST_WAIT_B:  operand2_q <= bus.i_rx_data;
          ST_WAIT_OP: opcode_q   <= bus.i_rx_data[NB_OP-1:0];
          default:    ;
        endcase
      end
      if (state_q == ST_EXEC) result_q <= bus.i_result;
      alu_valid_q <= alu_valid_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.o_operand1  = operand1_q;
  assign bus.o_operand2  = operand2_q;
  assign bus.o_opcode    = opcode_q;
  assign bus.o_alu_valid = alu_valid_q;
  assign bus.o_tx_start  = tx_start_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer: a table of full commands plus
// hand-written timeout, overrun and reset sequences.
module tb_uart_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  uart_alu_sequencer_if #(.NB_DATA(8), .NB_OP(6), .NB_OUT(16)) bus ();

  uart_alu_sequencer #(
    .NB_DATA        (8),
    .NB_OP          (6),
    .NB_OUT         (16),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [7:0]  opb;
    logic [15:0] result;
    int          busy;
    logic [5:0]  exp_opcode;
    logic [7:0]  exp_lo;
    logic [7:0]  exp_hi;
    bit          overrun;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] all_outputs();
    return {bus.o_operand1, bus.o_operand2, bus.o_opcode, bus.o_alu_valid, bus.o_tx_start,
            bus.o_tx_data, bus.o_busy, bus.o_frame_err, bus.o_overrun};
  endfunction

  // One rx_done pulse; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask

  // Starts at the negedge where o_tx_start is visible; models one byte transfer.
  task automatic xfer(input logic [7:0] exp, input bit inject, input string tag);
    check({tag, " tx_data at start"}, bus.o_tx_data, exp);
    bus.i_tx_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) check({tag, " tx_start one cycle"}, bus.o_tx_start, 0);
      if (inject && i == 0) begin
        bus.i_rx_data = 8'h77;
        bus.i_rx_done = 1'b1;
      end
      if (inject && i == 1) begin
        bus.i_rx_done = 1'b0;
        check({tag, " overrun pulse"}, bus.o_overrun, 1);
      end
      if (inject && i == 2) check({tag, " overrun cleared"}, bus.o_overrun, 0);
    end
    check({tag, " tx_data stable"}, bus.o_tx_data, exp);
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    bus.i_tx_busy = 1'b0;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask

  // Starts at the negedge one cycle after the 3rd byte was accepted (EXEC cycle).
  task automatic finish_tx(input vec_t v, input string tag);
    bit found = 1'b0;
    int lat = 0;
    for (int k = 2; k <= 80; k++) begin
      @(negedge clk);
      if (k == 2) check({tag, " alu_valid single pulse"}, bus.o_alu_valid, 0);
      if (bus.o_tx_start) begin
        found = 1'b1;
        lat = k;
        break;
      end
      bus.i_tx_busy = (k <= v.busy);
    end
    check({tag, " tx_start seen"}, found, 1);
    if (!found) return;
    check({tag, " tx_start latency"}, lat, 2 + v.busy);
    xfer(v.exp_lo, v.overrun, {tag, " lo"});
    check({tag, " tx_start hi launch"}, bus.o_tx_start, 1);
    xfer(v.exp_hi, 1'b0, {tag, " hi"});
    check({tag, " busy low at end"}, bus.o_busy, 0);
    check({tag, " no tx_start at end"}, bus.o_tx_start, 0);
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    bus.i_result = v.result;
    send_byte(v.op1);
    send_byte(v.op2);
    send_byte(v.opb);
    bus.i_tx_busy = (v.busy >= 1);
    check({tag, " alu_valid"}, bus.o_alu_valid, 1);
    check({tag, " operands"}, {bus.o_operand1, bus.o_operand2}, {v.op1, v.op2});
    check({tag, " opcode"}, bus.o_opcode, v.exp_opcode);
    check({tag, " busy in exec"}, bus.o_busy, 1);
    finish_tx(v, tag);
    check({tag, " operand1 kept"}, bus.o_operand1, v.op1);
  endtask

  // Asynchronous reset pulse away from the clock edge; all outputs must clear at once.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1 check({tag, " outputs cleared"}, all_outputs(), 0);
    @(negedge clk);
    bus.i_tx_busy = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t v;
    int lat;
    int starts;
    vecs[0] = '{8'h05, 8'h03, 8'h20, 16'h0008, 0,  6'h20, 8'h08, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h22, 16'hFF00, 10, 6'h22, 8'h00, 8'hFF, 1'b0};
    vecs[2] = '{8'hA5, 8'h5A, 8'hE5, 16'h00FF, 0,  6'h25, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'h12, 8'h34, 8'hC7, 16'hBEEF, 3,  6'h07, 8'hEF, 8'hBE, 1'b1};

    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    bus.i_result  = '0;
    bus.i_tx_busy = 1'b0;
    bus.i_tx_done = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", all_outputs(), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Single byte then silence: frame error 99 cycles after the byte edge.
    send_byte(8'h11);
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.o_frame_err) begin
        lat = k;
        break;
      end
    end
    check("timeout frame_err latency", lat, 99);
    check("timeout back to idle", bus.o_busy, 0);
    @(negedge clk);
    check("timeout frame_err one cycle", bus.o_frame_err, 0);
    run_cmd(vecs[0], "after timeout");

    // Third byte arrives in the very cycle the timeout expires: byte wins.
    v = '{8'hA0, 8'h0B, 8'h20, 16'h00AB, 0, 6'h20, 8'hAB, 8'h00, 1'b0};
    bus.i_result = v.result;
    send_byte(v.op1);
    send_byte(v.op2);
    repeat (97) @(negedge clk);
    send_byte(v.opb);
    check("race alu_valid", bus.o_alu_valid, 1);
    check("race no frame_err", bus.o_frame_err, 0);
    check("race opcode", bus.o_opcode, v.exp_opcode);
    finish_tx(v, "race");

    // Reset while collecting.
    send_byte(8'h42);
    check("wait_b operand1", bus.o_operand1, 8'h42);
    reset_pulse("rst wait_b");
    repeat (5) @(negedge clk);
    check("rst wait_b idle", bus.o_busy, 0);

    // Reset while waiting for the high byte to finish.
    bus.i_result = 16'h1234;
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h20);
    @(negedge clk);
    check("rst cmd tx_start lo", bus.o_tx_start, 1);
    xfer(8'h34, 1'b0, "rst cmd lo");
    check("rst cmd tx_start hi", bus.o_tx_start, 1);
    bus.i_tx_busy = 1'b1;
    @(negedge clk);
    check("rst cmd in wait_hi", {bus.o_busy, bus.o_tx_data}, {1'b1, 8'h12});
    reset_pulse("rst wait_hi");
    starts = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.i_tx_done = (k % 5 == 0);
      starts += int'(bus.o_tx_start) + int'(bus.o_busy);
    end
    bus.i_tx_done = 1'b0;
    check("no activity after reset", starts, 0);
    run_cmd(vecs[2], "after reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
